// File: rtl/uart_msg_seq.sv
// uart_msg_seq: plays parameter-stored messages out through a UART_Tx block using
// a send/busy handshake, with per-start message select, repeat count and abort.
// Optional feature macro: UART_MSG_SEQ_CRLF_EN appends CR (0x0D) and LF (0x0A)
// after every repetition of the message.
module uart_msg_seq #(
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_MSG_NUM         = 2,
  parameter int C_MSG_LEN         = 16,
  parameter logic [C_MSG_NUM*C_MSG_LEN*C_UART_DATA_WIDTH-1:0] C_MSG = '0,
  parameter logic [C_MSG_NUM*$clog2(C_MSG_LEN+1)-1:0] C_MSG_LENS = '0,
  parameter int C_REPEAT_W        = 4,
  localparam int SELW = (C_MSG_NUM > 1) ? $clog2(C_MSG_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         send,
  input  logic [SELW-1:0]              sel,
  input  logic [C_REPEAT_W-1:0]        repeat_n,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  input  logic                         txBusy,
  input  logic                         txErr,
  output logic                         txSend,
  output logic [C_UART_DATA_WIDTH-1:0] txData
);

  localparam int W  = C_UART_DATA_WIDTH;
  localparam int L  = C_MSG_LEN;
  localparam int LW = $clog2(C_MSG_LEN + 1);

`ifdef UART_MSG_SEQ_CRLF_EN
  localparam logic [W-1:0] CHAR_CR = W'(8'h0D);
  localparam logic [W-1:0] CHAR_LF = W'(8'h0A);
`endif

  typedef enum logic [2:0] {IDLE, REQ, WAIT, NEXT, END} tState;

  tState                 state;
  logic                  sendPrev;
  logic [SELW-1:0]       selReg;
  logic [C_REPEAT_W-1:0] repLeft;
  logic [LW-1:0]         byteIdx;
  logic                  stopPend;
`ifdef UART_MSG_SEQ_CRLF_EN
  // 0: message bytes, 1: CR in flight, 2: LF in flight
  logic [1:0]            termPh;
`endif

  // Message table unpacked into a byte ROM and a clamped length ROM
  logic [W-1:0]  romByte [C_MSG_NUM*L];
  logic [LW-1:0] romLen  [C_MSG_NUM];

  genvar gi, gj;
  generate
    for (gi = 0; gi < C_MSG_NUM; gi++) begin : gMsg
      localparam logic [LW-1:0] RAW_LEN = C_MSG_LENS[gi*LW +: LW];
      assign romLen[gi] = (RAW_LEN > LW'(L)) ? LW'(L) : RAW_LEN;
      for (gj = 0; gj < L; gj++) begin : gByte
        // byte 0 sits in the most significant W bits of its message slot
        assign romByte[gi*L+gj] = C_MSG[(gi+1)*L*W-1-gj*W -: W];
      end
    end
  endgenerate

  logic [SELW-1:0] rdMsg;
  logic [LW-1:0]   rdIdx;
  logic [LW-1:0]   curLen;
  logic [W-1:0]    rdByte;
  logic            selOk;
  logic            lastByte;

  // ROM lookup: in IDLE the live sel and byte 0, otherwise the byte that follows (wrapping to 0)
  always_comb begin
    rdMsg  = (state == IDLE) ? sel : selReg;
    curLen = '0;
    selOk  = 1'b0;
    for (int m = 0; m < C_MSG_NUM; m++) begin
      if (rdMsg == SELW'(m)) begin
        curLen = romLen[m];
        selOk  = 1'b1;
      end
    end
    lastByte = ((byteIdx + LW'(1)) == curLen);
    rdIdx    = ((state == IDLE) || lastByte) ? '0 : (byteIdx + LW'(1));
    rdByte   = '0;
    for (int m = 0; m < C_MSG_NUM; m++) begin
      for (int b = 0; b < L; b++) begin
        if ((rdMsg == SELW'(m)) && (rdIdx == LW'(b))) begin
          rdByte = romByte[m*L+b];
        end
      end
    end
  end

  // Sequencer FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      txSend   <= 1'b0;
      txData   <= '0;
      sendPrev <= 1'b1;
      selReg   <= '0;
      repLeft  <= '0;
      byteIdx  <= '0;
      stopPend <= 1'b0;
`ifdef UART_MSG_SEQ_CRLF_EN
      termPh   <= 2'd0;
`endif
    end else begin
      sendPrev <= send;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !abort && send && !sendPrev) begin
            selReg   <= sel;
            repLeft  <= (repeat_n == '0) ? C_REPEAT_W'(1) : repeat_n;
            byteIdx  <= '0;
            stopPend <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
            txData   <= rdByte;
            if (!selOk) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= END;
            end else if (curLen == '0) begin
`ifdef UART_MSG_SEQ_CRLF_EN
              termPh <= 2'd1;
              txData <= CHAR_CR;
              txSend <= 1'b1;
              state  <= REQ;
`else
              done  <= 1'b1;
              state <= END;
`endif
            end else begin
`ifdef UART_MSG_SEQ_CRLF_EN
              termPh <= 2'd0;
`endif
              txSend <= 1'b1;
              state  <= REQ;
            end
          end
        end
        REQ: begin
          if (txErr) begin
            error    <= 1'b1;
            stopPend <= 1'b1;
          end
          if (abort || !enable) stopPend <= 1'b1;
          if (txBusy) begin
            txSend <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (txErr) begin
            error    <= 1'b1;
            stopPend <= 1'b1;
          end
          if (abort || !enable) stopPend <= 1'b1;
          if (!txBusy) state <= NEXT;
        end
        NEXT: begin
          if (stopPend || abort || !enable) begin
            done  <= 1'b1;
            state <= END;
`ifdef UART_MSG_SEQ_CRLF_EN
          end else if ((termPh == 2'd0) && !lastByte) begin
            byteIdx <= rdIdx;
            txData  <= rdByte;
            txSend  <= 1'b1;
            state   <= REQ;
          end else if (termPh == 2'd0) begin
            termPh <= 2'd1;
            txData <= CHAR_CR;
            txSend <= 1'b1;
            state  <= REQ;
          end else if (termPh == 2'd1) begin
            termPh <= 2'd2;
            txData <= CHAR_LF;
            txSend <= 1'b1;
            state  <= REQ;
          end else if (repLeft <= C_REPEAT_W'(1)) begin
            done  <= 1'b1;
            state <= END;
          end else begin
            repLeft <= repLeft - C_REPEAT_W'(1);
            byteIdx <= '0;
            if (curLen == '0) begin
              termPh <= 2'd1;
              txData <= CHAR_CR;
            end else begin
              termPh <= 2'd0;
              txData <= rdByte;
            end
            txSend <= 1'b1;
            state  <= REQ;
          end
`else
          end else if (!lastByte) begin
            byteIdx <= rdIdx;
            txData  <= rdByte;
            txSend  <= 1'b1;
            state   <= REQ;
          end else if (repLeft <= C_REPEAT_W'(1)) begin
            done  <= 1'b1;
            state <= END;
          end else begin
            repLeft <= repLeft - C_REPEAT_W'(1);
            byteIdx <= '0;
            txData  <= rdByte;
            txSend  <= 1'b1;
            state   <= REQ;
          end
`endif
        end
        END: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_seq.sv
// tb_uart_msg_seq: directed stimulus for uart_msg_seq against a behavioural
// UART_Tx model; expected bytes and done pulses go into a scoreboard queue that
// a separate monitor thread drains as the model captures bytes.
`timescale 1ns/1ps
module tb_uart_msg_seq;

  localparam int W     = 8;
  localparam int NUM   = 3;
  localparam int L     = 5;
  localparam int LW    = 3;
  localparam int SELW  = 2;
  localparam int RW    = 4;
  // 921600 baud at 100 MHz is ~108.5 clocks per bit; 10-bit frame
  localparam int FRAME = 1090;
  localparam logic [NUM*L*W-1:0] MSGS = {40'h0000000000, 40'h4142000000, 40'h3132333435};
  localparam logic [NUM*LW-1:0]  LENS = {3'd0, 3'd2, 3'd5};

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic            enable   = 1'b0;
  logic            send     = 1'b0;
  logic [SELW-1:0] sel      = '0;
  logic [RW-1:0]   repeat_n = '0;
  logic            abort    = 1'b0;
  logic            txErr    = 1'b0;
  logic            txBusy   = 1'b0;
  logic            busy, done, error, txSend;
  logic [W-1:0]    txData;

  uart_msg_seq #(
    .C_UART_DATA_WIDTH(W),
    .C_MSG_NUM(NUM),
    .C_MSG_LEN(L),
    .C_MSG(MSGS),
    .C_MSG_LENS(LENS),
    .C_REPEAT_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .send(send), .sel(sel),
    .repeat_n(repeat_n), .abort(abort), .busy(busy), .done(done),
    .error(error), .txBusy(txBusy), .txErr(txErr), .txSend(txSend),
    .txData(txData)
  );

  always #5 clk = ~clk;

  // UART_Tx model: accepts txSend when idle, stays busy for one frame
  int           frameCnt = 0;
  int           capCnt   = 0;
  logic         capV     = 1'b0;
  logic [W-1:0] capD     = '0;
  always @(posedge clk) begin
    capV <= 1'b0;
    if (txBusy) begin
      if (frameCnt <= 1) txBusy <= 1'b0;
      frameCnt <= frameCnt - 1;
    end else if (txSend) begin
      txBusy   <= 1'b1;
      frameCnt <= FRAME;
      capV     <= 1'b1;
      capD     <= txData;
      capCnt   <= capCnt + 1;
    end
  end

  typedef struct {
    bit           isDone;
    logic [W-1:0] val;
  } evT;

  evT expQ[$];
  int nVec = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else begin
      $display("pass %s: 0x%0h", name, act);
    end
  endtask

  task automatic expByte(input logic [W-1:0] b);
    evT e;
    e.isDone = 1'b0;
    e.val    = b;
    expQ.push_back(e);
  endtask

  task automatic expDone(input logic err);
    evT e;
    e.isDone = 1'b1;
    e.val    = {{(W-1){1'b0}}, err};
    expQ.push_back(e);
  endtask

  task automatic expCrlf();
`ifdef UART_MSG_SEQ_CRLF_EN
    expByte(8'h0D);
    expByte(8'h0A);
`endif
  endtask

  // Monitor: pops one expectation per captured byte or done pulse
  task automatic monitor();
    evT e;
    forever begin
      @(negedge clk);
      if (capV) begin
        if (expQ.size() == 0) begin
          nVec++;
          nBad++;
          $display("FAIL unexpected byte: got 0x%0h, required none", capD);
        end else begin
          e = expQ.pop_front();
          chk("event kind (byte)", 32'(e.isDone), 32'd0);
          if (!e.isDone) chk("txByte", 32'(capD), 32'(e.val));
        end
      end
      if (done) begin
        if (expQ.size() == 0) begin
          nVec++;
          nBad++;
          $display("FAIL unexpected done: got error=%0d, required no done", error);
        end else begin
          e = expQ.pop_front();
          chk("event kind (done)", 32'(e.isDone), 32'd1);
          if (e.isDone) chk("done.error", 32'(error), 32'(e.val[0]));
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDone(input string name, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    chk({name, " done seen"}, 32'(done), 32'd1);
  endtask

  task automatic waitCap(input int target);
    int k;
    k = 0;
    while (capCnt < target && k < 20000) begin
      tick(1);
      k++;
    end
    chk("byte count reached", 32'(capCnt), 32'(target));
  endtask

  task automatic waitUartIdle();
    int k;
    k = 0;
    while (txBusy && k < 5000) begin
      tick(1);
      k++;
    end
    chk("uart model idle", 32'(txBusy), 32'd0);
  endtask

  initial begin
    int  c0;
    int  k;
    bit  busyLow;
    fork
      monitor();
    join_none

    // reset state
    rst = 1'b1;
    tick(3);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    chk("reset txSend", 32'(txSend), 32'd0);
    chk("reset txData", 32'(txData), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    tick(2);

    // message 0 once: "12345"
    expByte(8'h31); expByte(8'h32); expByte(8'h33); expByte(8'h34); expByte(8'h35);
    expCrlf();
    expDone(1'b0);
    sel = 2'd0; repeat_n = 4'd1; send = 1'b1;
    tick(1);
    chk("start busy", 32'(busy), 32'd1);
    chk("start txSend", 32'(txSend), 32'd1);
    chk("start txData", 32'(txData), 32'h31);
    send = 1'b0;
    waitDone("msg0", 20000);
    chk("msg0 error", 32'(error), 32'd0);
    tick(1);
    chk("busy after END", 32'(busy), 32'd0);
    tick(3);

    // message 1 three times, busy must stay high
    for (int r = 0; r < 3; r++) begin
      expByte(8'h41); expByte(8'h42);
      expCrlf();
    end
    expDone(1'b0);
    sel = 2'd1; repeat_n = 4'd3; send = 1'b1;
    tick(1);
    send = 1'b0;
    busyLow = 1'b0;
    k = 0;
    while (!done && k < 40000) begin
      if (!busy) busyLow = 1'b1;
      tick(1);
      k++;
    end
    chk("rep3 done seen", 32'(done), 32'd1);
    chk("rep3 busy held", 32'(busyLow), 32'd0);
    tick(3);

    // abort during the second byte
    expByte(8'h31); expByte(8'h32);
    expDone(1'b0);
    c0 = capCnt;
    sel = 2'd0; repeat_n = 4'd1; send = 1'b1;
    tick(1);
    send = 1'b0;
    waitCap(c0 + 2);
    tick(10);
    abort = 1'b1;
    waitDone("abort", 5000);
    abort = 1'b0;
    chk("abort error", 32'(error), 32'd0);
    tick(3);

    // txErr during the first byte of a two-repeat run
    expByte(8'h31);
    expDone(1'b1);
    c0 = capCnt;
    sel = 2'd0; repeat_n = 4'd2; send = 1'b1;
    tick(1);
    send = 1'b0;
    waitCap(c0 + 1);
    tick(5);
    txErr = 1'b1;
    tick(5);
    txErr = 1'b0;
    waitDone("txErr", 5000);
    tick(20);
    chk("error sticky", 32'(error), 32'd1);

    // zero-length message; accepted start clears error
`ifdef UART_MSG_SEQ_CRLF_EN
    expByte(8'h0D); expByte(8'h0A);
`endif
    expDone(1'b0);
    sel = 2'd2; repeat_n = 4'd1; send = 1'b1;
    tick(1);
    send = 1'b0;
    chk("len0 error cleared", 32'(error), 32'd0);
`ifdef UART_MSG_SEQ_CRLF_EN
    chk("len0 txSend", 32'(txSend), 32'd1);
`else
    chk("len0 txSend", 32'(txSend), 32'd0);
`endif
    waitDone("len0", 5000);
    tick(3);

    // out-of-range select
    expDone(1'b1);
    sel = 2'd3; repeat_n = 4'd1; send = 1'b1;
    tick(1);
    send = 1'b0;
    chk("badsel error", 32'(error), 32'd1);
    chk("badsel txSend", 32'(txSend), 32'd0);
    waitDone("badsel", 100);
    tick(3);

    // abort together with send: no start; enable low: no start
    abort = 1'b1; sel = 2'd0; send = 1'b1;
    tick(2);
    chk("abort+send busy", 32'(busy), 32'd0);
    send = 1'b0; abort = 1'b0;
    tick(2);
    enable = 1'b0; send = 1'b1;
    tick(2);
    chk("disabled busy", 32'(busy), 32'd0);
    send = 1'b0; enable = 1'b1;
    tick(2);

    // send held across END must not retrigger
    expByte(8'h41); expByte(8'h42);
    expCrlf();
    expDone(1'b0);
    sel = 2'd1; repeat_n = 4'd1; send = 1'b1;
    tick(1);
    chk("held-send error cleared", 32'(error), 32'd0);
    waitDone("held send", 10000);
    tick(30);
    chk("held-send no retrigger", 32'(busy), 32'd0);
    send = 1'b0;
    tick(2);

    // reset during the third byte, then send held high
    expByte(8'h31); expByte(8'h32); expByte(8'h33);
    c0 = capCnt;
    sel = 2'd0; repeat_n = 4'd1; send = 1'b1;
    tick(1);
    send = 1'b0;
    waitCap(c0 + 3);
    tick(10);
    send = 1'b1;
    rst  = 1'b1;
    tick(1);
    rst  = 1'b0;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst error", 32'(error), 32'd0);
    chk("midrst txSend", 32'(txSend), 32'd0);
    chk("midrst txData", 32'(txData), 32'd0);
    tick(20);
    chk("post-reset held send", 32'(busy), 32'd0);
    waitUartIdle();
    send = 1'b0;
    tick(1);

    // new edge after reset; repeat_n=0 acts as one pass
    expByte(8'h41); expByte(8'h42);
    expCrlf();
    expDone(1'b0);
    sel = 2'd1; repeat_n = 4'd0; send = 1'b1;
    tick(1);
    send = 1'b0;
    chk("restart busy", 32'(busy), 32'd1);
    waitDone("restart", 10000);
    tick(5);

    chk("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
